cntr_rmw_2p: RTL and testbench

Two-port read-modify-write counter engine that sits directly upstream of a 2-read/2-write memory atom. The counters themselves live in the atom. This block accepts up to two increment requests per cycle and issues the counter reads on the atom's read ports. It adds the increments, forwards in-flight results to close read-after-write hazards, and writes the updated counts back through the atom's write ports. Each updated count is also returned to the requester.

---
 rtl/cntr_rmw_2p_if.sv | 50 +++++
 rtl/cntr_rmw_2p.sv | 130 +++++++++++++
 tb/tb_cntr_rmw_2p.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cntr_rmw_2p_if.sv
// rtl/cntr_rmw_2p_if.sv - request/update and memory-atom bus of the two-port counter engine
interface cntr_rmw_2p_if #(
  parameter int BITADDR = 3,
  parameter int BITCNTR = 8
);
  logic               ready;
  logic               incr_0;
  logic               incr_1;
  logic [BITADDR-1:0] incr_adr_0;
  logic [BITADDR-1:0] incr_adr_1;
  logic [BITCNTR-1:0] incr_val_0;
  logic [BITCNTR-1:0] incr_val_1;
  logic               upd_vld_0;
  logic               upd_vld_1;
  logic [BITCNTR-1:0] upd_cnt_0;
  logic [BITCNTR-1:0] upd_cnt_1;
  logic               mem_ready;
  logic               mem_read_0;
  logic               mem_read_1;
  logic [BITADDR-1:0] mem_rd_adr_0;
  logic [BITADDR-1:0] mem_rd_adr_1;
  logic [BITCNTR-1:0] mem_rd_dout_0;
  logic [BITCNTR-1:0] mem_rd_dout_1;
  logic               mem_write_2;
  logic               mem_write_3;
  logic [BITADDR-1:0] mem_wr_adr_2;
  logic [BITADDR-1:0] mem_wr_adr_3;
  logic [BITCNTR-1:0] mem_wr_din_2;
  logic [BITCNTR-1:0] mem_wr_din_3;

  modport slave (
    output ready,
    input  incr_0, incr_1, incr_adr_0, incr_adr_1, incr_val_0, incr_val_1,
    output upd_vld_0, upd_vld_1, upd_cnt_0, upd_cnt_1,
    input  mem_ready, mem_rd_dout_0, mem_rd_dout_1,
    output mem_read_0, mem_read_1, mem_rd_adr_0, mem_rd_adr_1,
    output mem_write_2, mem_write_3, mem_wr_adr_2, mem_wr_adr_3,
    output mem_wr_din_2, mem_wr_din_3
  );

  modport master (
    input  ready,
    output incr_0, incr_1, incr_adr_0, incr_adr_1, incr_val_0, incr_val_1,
    input  upd_vld_0, upd_vld_1, upd_cnt_0, upd_cnt_1,
    output mem_ready, mem_rd_dout_0, mem_rd_dout_1,
    input  mem_read_0, mem_read_1, mem_rd_adr_0, mem_rd_adr_1,
    input  mem_write_2, mem_write_3, mem_wr_adr_2, mem_wr_adr_3,
    input  mem_wr_din_2, mem_wr_din_3
  );
endinterface

// File: rtl/cntr_rmw_2p.sv
// rtl/cntr_rmw_2p.sv - two-port read-modify-write counter engine with write-back forwarding
// Optional feature macro: CNTR_RMW_SATURATE_EN (clamp additions instead of wrapping).
module cntr_rmw_2p #(
  parameter int NUMADDR    = 8,
  parameter int BITADDR    = 3,
  parameter int BITCNTR    = 8,
  parameter int SRAM_DELAY = 0
) (
  input logic          clk,
  input logic          rst,
  cntr_rmw_2p_if.slave bus
);

  if (NUMADDR > (1 << BITADDR)) begin : g_numaddr_check
    $error("cntr_rmw_2p: NUMADDR does not fit in BITADDR");
  end

  function automatic logic [BITCNTR-1:0] cnt_add(input logic [BITCNTR-1:0] a,
                                                 input logic [BITCNTR-1:0] b);
`ifdef CNTR_RMW_SATURATE_EN
    logic [BITCNTR:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[BITCNTR] ? {BITCNTR{1'b1}} : sum[BITCNTR-1:0];
`else
    return a + b;
`endif
  endfunction

  logic                    rdy;
  logic [1:0]              acc;
  logic [1:0][BITADDR-1:0] acc_adr;
  logic [1:0][BITCNTR-1:0] acc_val;
  logic [1:0]              c_vld;
  logic [1:0][BITADDR-1:0] c_adr;
  logic [1:0][BITCNTR-1:0] c_val;
  logic [1:0][BITCNTR-1:0] rd_dout;
  logic [1:0][BITCNTR-1:0] base;
  logic [BITCNTR-1:0]      new_0;
  logic [BITCNTR-1:0]      new_1;
  logic                    collide;

  assign rdy       = !rst && bus.mem_ready;
  assign bus.ready = rdy;

  assign acc     = {bus.incr_1, bus.incr_0} & {2{rdy}};
  assign acc_adr = {bus.incr_adr_1, bus.incr_adr_0};
  assign acc_val = {bus.incr_val_1, bus.incr_val_0};
  assign rd_dout = {bus.mem_rd_dout_1, bus.mem_rd_dout_0};

  assign bus.mem_read_0   = acc[0];
  assign bus.mem_read_1   = acc[1];
  assign bus.mem_rd_adr_0 = bus.incr_adr_0;
  assign bus.mem_rd_adr_1 = bus.incr_adr_1;

  // Request delay line matched to the atom read latency.
  if (SRAM_DELAY == 0) begin : g_nopipe
    assign c_vld = acc;
    assign c_adr = acc_adr;
    assign c_val = acc_val;
  end else begin : g_pipe
    logic [SRAM_DELAY-1:0][1:0]              p_vld;
    logic [SRAM_DELAY-1:0][1:0][BITADDR-1:0] p_adr;
    logic [SRAM_DELAY-1:0][1:0][BITCNTR-1:0] p_val;

    always_ff @(posedge clk) begin
      if (rst) begin
        p_vld <= '0;
      end else begin
        for (int i = SRAM_DELAY - 1; i > 0; i--) begin
          p_vld[i] <= p_vld[i-1];
          p_adr[i] <= p_adr[i-1];
          p_val[i] <= p_val[i-1];
        end
        p_vld[0] <= acc;
        p_adr[0] <= acc_adr;
        p_val[0] <= acc_val;
      end
    end

    assign c_vld = p_vld[SRAM_DELAY-1];
    assign c_adr = p_adr[SRAM_DELAY-1];
    assign c_val = p_val[SRAM_DELAY-1];
  end

  // The write being driven now is not yet in the atom; port 1's is the newer value.
  always_comb begin
    base = rd_dout;
    for (int k = 0; k < 2; k++) begin
      if (bus.mem_write_3 && (bus.mem_wr_adr_3 == c_adr[k])) begin
        base[k] = bus.mem_wr_din_3;
      end else if (bus.mem_write_2 && (bus.mem_wr_adr_2 == c_adr[k])) begin
        base[k] = bus.mem_wr_din_2;
      end
    end
    collide = c_vld[0] && c_vld[1] && (c_adr[0] == c_adr[1]);
    new_0   = cnt_add(base[0], c_val[0]);
    new_1   = cnt_add(collide ? new_0 : base[1], c_val[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.upd_vld_0    <= 1'b0;
      bus.upd_vld_1    <= 1'b0;
      bus.upd_cnt_0    <= '0;
      bus.upd_cnt_1    <= '0;
      bus.mem_write_2  <= 1'b0;
      bus.mem_write_3  <= 1'b0;
      bus.mem_wr_adr_2 <= '0;
      bus.mem_wr_adr_3 <= '0;
      bus.mem_wr_din_2 <= '0;
      bus.mem_wr_din_3 <= '0;
    end else begin
      bus.upd_vld_0   <= c_vld[0];
      bus.upd_vld_1   <= c_vld[1];
      bus.mem_write_2 <= c_vld[0] && !collide;
      bus.mem_write_3 <= c_vld[1];
      if (c_vld[0]) begin
        bus.upd_cnt_0    <= new_0;
        bus.mem_wr_adr_2 <= c_adr[0];
        bus.mem_wr_din_2 <= new_0;
      end
      if (c_vld[1]) begin
        bus.upd_cnt_1    <= new_1;
        bus.mem_wr_adr_3 <= c_adr[1];
        bus.mem_wr_din_3 <= new_1;
      end
    end
  end

endmodule

// File: tb/tb_cntr_rmw_2p.sv
// tb/tb_cntr_rmw_2p.sv - directed and randomized self-checking bench for cntr_rmw_2p
`timescale 1ns/1ps
module tb_cntr_rmw_2p;
  localparam int NUMADDR = 8;
  localparam int BITADDR = 3;
  localparam int BITCNTR = 8;
  localparam int D       = 1;
`ifdef CNTR_RMW_SATURATE_EN
  localparam int OVF_RESULT = 255;
`else
  localparam int OVF_RESULT = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cntr_rmw_2p_if #(.BITADDR(BITADDR), .BITCNTR(BITCNTR)) bus ();

  cntr_rmw_2p #(
    .NUMADDR(NUMADDR), .BITADDR(BITADDR), .BITCNTR(BITCNTR), .SRAM_DELAY(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Atom stand-in: one-cycle read latency, data sampled from current contents.
  logic [BITCNTR-1:0] atom [NUMADDR] = '{default: '0};
  logic [BITADDR-1:0] rd_q0 = '0;
  logic [BITADDR-1:0] rd_q1 = '0;
  logic               pl_en  = 1'b0;
  logic [BITADDR-1:0] pl_adr = '0;
  logic [BITCNTR-1:0] pl_dat = '0;

  always @(posedge clk) begin
    rd_q0 <= bus.mem_rd_adr_0;
    rd_q1 <= bus.mem_rd_adr_1;
    if (pl_en) atom[pl_adr] <= pl_dat;
    if (bus.mem_write_2) atom[bus.mem_wr_adr_2] <= bus.mem_wr_din_2;
    if (bus.mem_write_3) atom[bus.mem_wr_adr_3] <= bus.mem_wr_din_3;
  end
  assign bus.mem_rd_dout_0 = atom[rd_q0];
  assign bus.mem_rd_dout_1 = atom[rd_q1];

  // Reference model: requests retire in order, port 0 before port 1 of the same cycle.
  typedef struct {
    int                 due;
    logic [BITADDR-1:0] adr;
    logic [BITCNTR-1:0] val;
    logic [BITCNTR:0]   pin;
  } req_t;

  req_t               q0[$];
  req_t               q1[$];
  logic [BITCNTR-1:0] cm [NUMADDR] = '{default: '0};
  logic [BITCNTR:0]   pin_0 = '0;
  logic [BITCNTR:0]   pin_1 = '0;
  int                 cyc     = 0;
  int                 n_tests = 0;
  int                 n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BITCNTR-1:0] model_add(input int a, input int b);
    int s;
    int lim;
    lim = 1 << BITCNTR;
    s   = a + b;
`ifdef CNTR_RMW_SATURATE_EN
    if (s >= lim) s = lim - 1;
`else
    s = s % lim;
`endif
    return BITCNTR'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  logic               er, a0, a1, h0, h1, coll;
  req_t               r0, r1;
  logic [BITCNTR-1:0] n0, n1;

  always @(negedge clk) begin
    er = !rst && bus.mem_ready;
    a0 = er && bus.incr_0;
    a1 = er && bus.incr_1;
    chk("ready", 32'(bus.ready), 32'(er));
    chk("mem_read_0", 32'(bus.mem_read_0), 32'(a0));
    chk("mem_read_1", 32'(bus.mem_read_1), 32'(a1));
    if (a0) chk("mem_rd_adr_0", 32'(bus.mem_rd_adr_0), 32'(bus.incr_adr_0));
    if (a1) chk("mem_rd_adr_1", 32'(bus.mem_rd_adr_1), 32'(bus.incr_adr_1));

    h0 = (q0.size() > 0) && (q0[0].due == cyc);
    h1 = (q1.size() > 0) && (q1[0].due == cyc);
    coll = 1'b0;
    n0 = '0;
    n1 = '0;
    if (h0) begin
      r0 = q0.pop_front();
      n0 = model_add(int'(cm[r0.adr]), int'(r0.val));
      cm[r0.adr] = n0;
    end
    if (h1) begin
      r1 = q1.pop_front();
      n1 = model_add(int'(cm[r1.adr]), int'(r1.val));
      cm[r1.adr] = n1;
      coll = h0 && (r0.adr == r1.adr);
    end

    chk("upd_vld_0", 32'(bus.upd_vld_0), 32'(h0));
    chk("upd_vld_1", 32'(bus.upd_vld_1), 32'(h1));
    chk("mem_write_2", 32'(bus.mem_write_2), 32'(h0 && !coll));
    chk("mem_write_3", 32'(bus.mem_write_3), 32'(h1));
    if (h0) begin
      chk("upd_cnt_0", 32'(bus.upd_cnt_0), 32'(n0));
      if (!coll) begin
        chk("mem_wr_adr_2", 32'(bus.mem_wr_adr_2), 32'(r0.adr));
        chk("mem_wr_din_2", 32'(bus.mem_wr_din_2), 32'(n0));
      end
      if (r0.pin[BITCNTR]) chk("model_pin_0", 32'(n0), 32'(r0.pin[BITCNTR-1:0]));
    end
    if (h1) begin
      chk("upd_cnt_1", 32'(bus.upd_cnt_1), 32'(n1));
      chk("mem_wr_adr_3", 32'(bus.mem_wr_adr_3), 32'(r1.adr));
      chk("mem_wr_din_3", 32'(bus.mem_wr_din_3), 32'(n1));
      if (r1.pin[BITCNTR]) chk("model_pin_1", 32'(n1), 32'(r1.pin[BITCNTR-1:0]));
    end

    if (pl_en) cm[pl_adr] = pl_dat;
    // Anything still before its write-back when reset is seen never reaches the atom.
    if (rst) begin
      while (q0.size() > 0 && q0[$].due > cyc) void'(q0.pop_back());
      while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
    end
    if (a0) q0.push_back('{due: cyc + D + 1, adr: bus.incr_adr_0, val: bus.incr_val_0, pin: pin_0});
    if (a1) q1.push_back('{due: cyc + D + 1, adr: bus.incr_adr_1, val: bus.incr_val_1, pin: pin_1});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input int d);
    pl_en  = 1'b1;
    pl_adr = BITADDR'(a);
    pl_dat = BITCNTR'(d);
    tick();
    pl_en  = 1'b0;
  endtask

  // p0/p1 < 0 means no hand-computed expectation for that request.
  task automatic req(input logic i0, input int ad0, input int v0, input int p0,
                     input logic i1, input int ad1, input int v1, input int p1);
    bus.incr_0     = i0;
    bus.incr_adr_0 = BITADDR'(ad0);
    bus.incr_val_0 = BITCNTR'(v0);
    pin_0          = (p0 < 0) ? '0 : {1'b1, BITCNTR'(p0)};
    bus.incr_1     = i1;
    bus.incr_adr_1 = BITADDR'(ad1);
    bus.incr_val_1 = BITCNTR'(v1);
    pin_1          = (p1 < 0) ? '0 : {1'b1, BITCNTR'(p1)};
    tick();
    bus.incr_0 = 1'b0;
    bus.incr_1 = 1'b0;
    pin_0      = '0;
    pin_1      = '0;
  endtask

  initial begin
    bus.mem_ready  = 1'b1;
    bus.incr_0     = 1'b0;
    bus.incr_1     = 1'b0;
    bus.incr_adr_0 = '0;
    bus.incr_adr_1 = '0;
    bus.incr_val_0 = '0;
    bus.incr_val_1 = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    preload(3, 5);
    req(1, 3, 2, 7, 0, 0, 0, -1);
    repeat (3) tick();

    preload(4, 0);
    req(1, 4, 1, 1, 0, 0, 0, -1);
    req(1, 4, 1, 2, 0, 0, 0, -1);
    req(1, 4, 1, 3, 0, 0, 0, -1);
    repeat (3) tick();

    preload(6, 10);
    req(1, 6, 3, 13, 1, 6, 4, 17);
    repeat (3) tick();

    preload(2, 0);
    req(0, 0, 0, -1, 1, 2, 5, 5);
    req(1, 2, 1, 6, 0, 0, 0, -1);
    repeat (3) tick();

    preload(5, 250);
    req(1, 5, 10, OVF_RESULT, 0, 0, 0, -1);
    repeat (3) tick();

    preload(1, 20);
    req(1, 1, 9, -1, 0, 0, 0, -1);
    rst            = 1'b1;
    bus.incr_1     = 1'b1;
    bus.incr_adr_1 = 3'd1;
    bus.incr_val_1 = 8'd7;
    tick();
    rst        = 1'b0;
    bus.incr_1 = 1'b0;
    repeat (3) tick();
    req(1, 1, 1, 21, 0, 0, 0, -1);
    repeat (3) tick();

    for (int a = 0; a < NUMADDR; a++) preload(a, int'($urandom_range(255)));
    repeat (3000) begin
      bus.mem_ready  = ($urandom_range(15) != 0);
      rst            = ($urandom_range(99) == 0);
      bus.incr_0     = ($urandom_range(3) != 0);
      bus.incr_1     = ($urandom_range(3) != 0);
      bus.incr_adr_0 = BITADDR'(($urandom_range(3) == 0) ? $urandom_range(7) : $urandom_range(1));
      bus.incr_adr_1 = BITADDR'(($urandom_range(3) == 0) ? $urandom_range(7) : $urandom_range(1));
      bus.incr_val_0 = BITCNTR'($urandom_range(255));
      bus.incr_val_1 = BITCNTR'($urandom_range(255));
      tick();
    end
    rst           = 1'b0;
    bus.incr_0    = 1'b0;
    bus.incr_1    = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
